// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM state type, IR field slices and the
// decoded-instruction bundle shared by the CPU control unit files.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_LDI   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_INC   = 4'hA;
    localparam logic [3:0] OP_DEC   = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int IR_OP_MSB  = 7;
    localparam int IR_OP_LSB  = 4;
    localparam int IR_FLD_MSB = 3;
    localparam int IR_FLD_LSB = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_EXECUTE,
        S_HALT
    } cu_state_t;

    typedef struct packed {
        logic is_alu;
        logic needs_mem;
        logic writes_acc;
        logic is_jump;
        logic is_illegal;
    } dec_t;

    function automatic logic [3:0] ir_op(input logic [7:0] ir);
        return ir[IR_OP_MSB:IR_OP_LSB];
    endfunction

    function automatic logic [3:0] ir_fld(input logic [7:0] ir);
        return ir[IR_FLD_MSB:IR_FLD_LSB];
    endfunction

endpackage

// File: rtl/cpu_decoder.sv
// cpu_decoder: combinational IR -> control class bits.
// is_alu means the ALU is driven in EXECUTE (ALU ops, JZ, INC, DEC).
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] ir,
    output dec_t       dec
);

    logic [3:0] op;

    assign op = ir_op(ir);

    // classify the opcode; reserved encodings fall to default
    always_comb begin
        dec = '0;
        unique case (1'b1)
            (op == OP_NOP),
            (op == OP_HALT): begin
            end
            (op == OP_STORE): begin
            end
            (op == OP_LOAD): begin
                dec.needs_mem  = 1'b1;
                dec.writes_acc = 1'b1;
            end
            (op == OP_ADD),
            (op == OP_SUB),
            (op == OP_AND),
            (op == OP_OR): begin
                dec.is_alu     = 1'b1;
                dec.needs_mem  = 1'b1;
                dec.writes_acc = 1'b1;
            end
            (op == OP_INC),
            (op == OP_DEC): begin
                dec.is_alu     = 1'b1;
                dec.writes_acc = 1'b1;
            end
            (op == OP_LDI): begin
                dec.writes_acc = 1'b1;
            end
            (op == OP_JMP): begin
                dec.is_jump = 1'b1;
            end
            (op == OP_JZ): begin
                dec.is_alu  = 1'b1;
                dec.is_jump = 1'b1;
            end
            default: begin
                dec.is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle sequencer owning PC, ACC and Z.
// CU_ILLEGAL_TRAP_EN: reserved opcodes halt and set illegal_op.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [7:0]        imem_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              zero_flag,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic              illegal_op,
`endif
    output logic              halted
);

`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    cu_state_t         state_q;
    cu_state_t         state_d;
    logic [7:0]        ir_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] opnd_q;
    logic              z_q;
    dec_t              dec;
    logic [3:0]        op;
    logic [3:0]        fld;
    logic [DATA_W-1:0] ld_val;
    logic              trap;

    assign op     = ir_op(ir_q);
    assign fld    = ir_fld(ir_q);
    assign ld_val = (op == OP_LDI) ? DATA_W'(fld) : opnd_q;
    assign trap   = TRAP_EN && dec.is_illegal;

    cpu_decoder u_dec (
        .ir  (ir_q),
        .dec (dec)
    );

    assign imem_addr  = pc_q;
    assign dmem_addr  = ADDR_W'(fld);
    assign dmem_wdata = acc_q;
    assign alu_a      = acc_q;
    assign alu_b      = opnd_q;
    assign pc         = pc_q;
    assign acc        = acc_q;
    assign zero_flag  = z_q;
    assign halted     = (state_q == S_HALT) && !rst;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // next state and bus strobes; strobes forced low while in reset
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_opcode = 4'h0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_HALT || trap) state_d = S_HALT;
                else if (dec.needs_mem)    state_d = S_MEM_RD;
                else                       state_d = S_EXECUTE;
            end
            S_MEM_RD: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (dec.is_alu) alu_opcode = op;
                dmem_we = (op == OP_STORE);
                state_d = S_FETCH;
            end
            S_HALT: begin
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (rst) begin
            imem_req   = 1'b0;
            dmem_we    = 1'b0;
            alu_opcode = 4'h0;
        end
    end

    // architectural state: IR, PC, operand latch, ACC, Z
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q   <= '0;
            pc_q   <= '0;
            opnd_q <= '0;
            acc_q  <= '0;
            z_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir_q <= imem_rdata;
                        pc_q <= pc_q + ADDR_W'(1);
                    end
                end
                S_MEM_RD: begin
                    opnd_q <= dmem_rdata;
                end
                S_EXECUTE: begin
                    if (dec.writes_acc) begin
                        if (dec.is_alu) begin
                            acc_q <= alu_result;
                            z_q   <= alu_zero;
                        end else begin
                            acc_q <= ld_val;
                            z_q   <= (ld_val == '0);
                        end
                    end
                    if (dec.is_jump && (op == OP_JMP || alu_zero))
                        pc_q <= ADDR_W'(fld);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;

    assign illegal_op = illegal_q;

    // sticky flag raised when a reserved opcode is decoded
    always_ff @(posedge clk) begin
        if (rst)
            illegal_q <= 1'b0;
        else if (state_q == S_DECODE && dec.is_illegal)
            illegal_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed and random programs checked against
// an instruction-level ISA model; memories and ALU live in the bench.
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_rdata;
    logic [3:0] dmem_addr;
    logic       dmem_we;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic [3:0] pc;
    logic [7:0] acc;
    logic       zero_flag;
    logic       halted;
`ifdef CU_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    cpu_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .acc        (acc),
        .zero_flag  (zero_flag),
`ifdef CU_ILLEGAL_TRAP_EN
        .illegal_op (illegal_op),
`endif
        .halted     (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] prog  [16];
    logic [7:0] dinit [16];
    logic [7:0] dmem  [16];
    logic       load_mem = 1'b0;

    // data memory: registered read, write strobe, bulk preload
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) dmem[i] <= dinit[i];
        end else begin
            dmem_rdata <= dmem[dmem_addr];
            if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
        end
    end

    // ALU: A op B, JZ passes A through
    always_comb begin
        alu_result = 8'h00;
        case (alu_opcode)
            4'h3: alu_result = alu_a + alu_b;
            4'h4: alu_result = alu_a - alu_b;
            4'h5: alu_result = alu_a & alu_b;
            4'h6: alu_result = alu_a | alu_b;
            4'h9: alu_result = alu_a;
            4'hA: alu_result = alu_a + 8'h01;
            4'hB: alu_result = alu_a - 8'h01;
            default: alu_result = 8'h00;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    int errors = 0;
    int checks = 0;

    int         m_pc;
    logic [7:0] m_acc;
    logic       m_z;
    logic       m_halt;
    logic       m_ill;
    logic [7:0] m_mem [16];

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] dut_mem();
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = dmem[i];
        return v;
    endfunction

    function automatic logic [127:0] ref_mem();
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_mem[i];
        return v;
    endfunction

    function automatic bit uses_mem(input logic [7:0] ins);
        int o = int'(ins[7:4]);
        return (o == 1) || (o >= 3 && o <= 6);
    endfunction

    task automatic model_reset();
        m_pc   = 0;
        m_acc  = 8'h00;
        m_z    = 1'b0;
        m_halt = 1'b0;
        m_ill  = 1'b0;
    endtask

    // execute one instruction at ISA level; lat = cycles to next fetch
    task automatic model_step(input logic [7:0] ins, output int lat);
        int f = int'(ins[3:0]);
        m_pc = (m_pc + 1) % 16;
        lat  = uses_mem(ins) ? 4 : 3;
        case (int'(ins[7:4]))
            1:  begin m_acc = m_mem[f];           m_z = (m_acc == 0); end
            2:  m_mem[f] = m_acc;
            3:  begin m_acc = m_acc + m_mem[f];   m_z = (m_acc == 0); end
            4:  begin m_acc = m_acc - m_mem[f];   m_z = (m_acc == 0); end
            5:  begin m_acc = m_acc & m_mem[f];   m_z = (m_acc == 0); end
            6:  begin m_acc = m_acc | m_mem[f];   m_z = (m_acc == 0); end
            7:  m_pc = f;
            8:  begin m_acc = 8'(f);              m_z = (m_acc == 0); end
            9:  if (m_acc == 0) m_pc = f;
            10: begin m_acc = m_acc + 8'd1;       m_z = (m_acc == 0); end
            11: begin m_acc = m_acc - 8'd1;       m_z = (m_acc == 0); end
            15: m_halt = 1'b1;
            12, 13, 14: begin
`ifdef CU_ILLEGAL_TRAP_EN
                m_halt = 1'b1;
                m_ill  = 1'b1;
`endif
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 8'h00;
        load_mem   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_acc", acc, 0);
        check("rst_z", zero_flag, 0);
        check("rst_req", imem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_aluop", alu_opcode, 0);
        check("rst_halted", halted, 0);
`ifdef CU_ILLEGAL_TRAP_EN
        check("rst_illegal", illegal_op, 0);
`endif
        load_mem = 1'b0;
        rst      = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = dinit[i];
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            prog[i]  = 8'h00;
            dinit[i] = 8'h00;
        end
    endtask

    // serve fetches with wmin..wmax wait cycles; optionally reset
    // during MEM_RD of instruction number abort_at
    task automatic run(input int max_instr, input int wmin,
                       input int wmax, input int abort_at);
        int         n       = 0;
        int         wl      = -1;
        int         since   = -1;
        int         exp_lat = 0;
        int         guard   = 0;
        bit         abort   = 1'b0;
        bit         done    = 1'b0;
        logic [7:0] ins;
        while (!done) begin
            @(negedge clk);
            guard++;
            if (since >= 0) since++;
            imem_valid = 1'b0;
            imem_rdata = 8'($urandom);
            if (guard > 3000) begin
                check("timeout", 1, 0);
                done = 1'b1;
            end else if (abort && since == 2) begin
                rst = 1'b1;
                @(negedge clk);
                check("abort_pc", pc, 0);
                check("abort_acc", acc, 0);
                check("abort_z", zero_flag, 0);
                check("abort_req", imem_req, 0);
                check("abort_we", dmem_we, 0);
                rst = 1'b0;
                model_reset();
                abort = 1'b0;
                since = -1;
                wl    = -1;
            end else if (m_halt && since >= 3) begin
                check("halt_flag", halted, 1);
                check("halt_req", imem_req, 0);
                check("halt_pc", pc, m_pc);
                check("halt_acc", acc, m_acc);
                check("halt_z", zero_flag, m_z);
                check("halt_mem", dut_mem(), ref_mem());
`ifdef CU_ILLEGAL_TRAP_EN
                check("halt_illegal", illegal_op, m_ill);
`endif
                repeat (3) @(negedge clk);
                check("halt_frozen", pc, m_pc);
                check("halt_stays", halted, 1);
                done = 1'b1;
            end else if (imem_req) begin
                if (wl < 0) begin
                    check("pc", pc, m_pc);
                    check("acc", acc, m_acc);
                    check("z", zero_flag, m_z);
                    check("mem", dut_mem(), ref_mem());
                    check("not_halted", halted, 0);
                    if (since >= 0) check("latency", since, exp_lat);
                    if (n >= max_instr) done = 1'b1;
                    wl = $urandom_range(wmax, wmin);
                end
                if (!done) begin
                    if (wl > 0) begin
                        check("wait_pc", pc, m_pc);
                        check("wait_we", dmem_we, 0);
                        wl--;
                    end else begin
                        check("imem_addr", imem_addr, m_pc);
                        ins        = prog[m_pc];
                        imem_valid = 1'b1;
                        imem_rdata = prog[imem_addr];
                        model_step(ins, exp_lat);
                        n++;
                        since = 0;
                        wl    = -1;
                        if (n == abort_at && uses_mem(ins)) abort = 1'b1;
                    end
                end
            end
        end
        imem_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 8'h00;

        clear_prog();
        prog[0] = 8'h85; prog[1] = 8'hA0;
        prog[2] = 8'h23; prog[3] = 8'hF0;
        do_reset();
        run(10, 0, 0, 0);
        check("t1_m3", dmem[3], 8'h06);
        check("t1_acc", acc, 8'h06);
        check("t1_z", zero_flag, 0);
        check("t1_pc", pc, 4'h4);

        clear_prog();
        dinit[2] = 8'h05;
        prog[0] = 8'h85; prog[1] = 8'h42;
        prog[2] = 8'h99; prog[9] = 8'hF0;
        do_reset();
        run(10, 0, 0, 0);
        check("t2a_acc", acc, 8'h00);
        check("t2a_z", zero_flag, 1);
        check("t2a_pc", pc, 4'hA);

        dinit[2] = 8'h04;
        prog[3]  = 8'hF0;
        do_reset();
        run(10, 0, 0, 0);
        check("t2b_acc", acc, 8'h01);
        check("t2b_z", zero_flag, 0);
        check("t2b_pc", pc, 4'h4);

        clear_prog();
        prog[0] = 8'h80; prog[1] = 8'hB0;
        prog[2] = 8'hA0; prog[3] = 8'hF0;
        do_reset();
        run(10, 0, 0, 0);
        check("t3_acc", acc, 8'h00);
        check("t3_z", zero_flag, 1);

        clear_prog();
        prog[0] = 8'h85; prog[1] = 8'h23; prog[2] = 8'hF0;
        do_reset();
        run(10, 5, 5, 0);
        check("t4_m3", dmem[3], 8'h05);

        clear_prog();
        dinit[1] = 8'h03;
        prog[0] = 8'h87; prog[1] = 8'h31; prog[2] = 8'hF0;
        do_reset();
        run(10, 0, 1, 2);
        check("t5_acc", acc, 8'h0A);
        check("t5_pc", pc, 4'h3);

        clear_prog();
        prog[4] = 8'hF0;
        do_reset();
        run(10, 0, 0, 0);
        check("t6_halted", halted, 1);
        check("t6_pc", pc, 4'h5);

        clear_prog();
        prog[0] = 8'hC0; prog[1] = 8'hF0;
        do_reset();
        run(10, 0, 0, 0);
        check("t6i_halted", halted, 1);
`ifdef CU_ILLEGAL_TRAP_EN
        check("t6i_illegal", illegal_op, 1);
        check("t6i_pc", pc, 4'h1);
`else
        check("t6i_pc", pc, 4'h2);
`endif

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 16; i++) begin
                prog[i]  = 8'($urandom);
                dinit[i] = 8'($urandom);
            end
            do_reset();
            run(40, 0, 2, (r % 3 == 0) ? $urandom_range(20, 1) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
